// File: rtl/systolic_sequencer.sv
// Instruction sequencer for the systolic array: decodes 5-bit words and drives load/feed/flush/drain strobes.
// Optional busy-cycle performance counter is enabled with `define SEQ_PERF_CNT_EN.
module systolic_sequencer #(
  parameter int ARRAY_N      = 4,
  parameter int FLUSH_CYCLES = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [4:0]                 instruction,
  output logic                       systolic_array_done,
  output logic                       busy,
  output logic                       w_load,
  output logic [$clog2(ARRAY_N)-1:0] w_row,
  output logic [2:0]                 w_bank,
  output logic                       acc_clear,
  output logic                       a_valid,
  output logic [2:0]                 a_idx,
  output logic                       r_shift,
  output logic [$clog2(ARRAY_N)-1:0] r_row,
  output logic [15:0]                busy_cycles
);

  localparam int RW = $clog2(ARRAY_N);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [RW-1:0] ROW_LAST   = RW'(ARRAY_N - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_LOAD_W  = 2'b01,
    OP_COMPUTE = 2'b10,
    OP_DRAIN   = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE,
    S_SETTLE
  } state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic [2:0]    field_q, field_d;
  logic [RW-1:0] row_q, row_d;
  logic [2:0]    feed_q, feed_d;
  logic [FW-1:0] flush_q, flush_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      field_q <= '0;
      row_q   <= '0;
      feed_q  <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      field_q <= field_d;
      row_q   <= row_d;
      feed_q  <= feed_d;
      flush_q <= flush_d;
    end
  end

  // NOTE: every variable gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    field_d = field_q;
    row_d   = row_q;
    feed_d  = feed_q;
    flush_d = flush_q;
    unique case (state_q)
      S_IDLE: begin
        if (!busy_q) begin
          busy_d = start;
        end else if (instruction == 5'd0) begin
          busy_d = 1'b0;
        end else begin
          field_d = instruction[2:0];
          row_d   = '0;
          feed_d  = '0;
          flush_d = '0;
          unique case (opcode_t'(instruction[4:3]))
            OP_NOP:     state_d = S_DONE;
            OP_LOAD_W:  state_d = S_LOAD_W;
            OP_COMPUTE: state_d = S_CLEAR;
            OP_DRAIN:   state_d = S_DRAIN;
            default:    state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD_W, S_DRAIN: begin
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          state_d = S_DONE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_CLEAR: state_d = S_FEED;
      S_FEED: begin
        if (feed_q == field_q) begin
          feed_d  = '0;
          state_d = S_FLUSH;
        end else begin
          feed_d = feed_q + 3'd1;
        end
      end
      S_FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          flush_d = '0;
          state_d = S_DONE;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      S_DONE:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes and indices are pure decodes of registered state; indices read zero outside their state.
  assign busy                = busy_q;
  assign systolic_array_done = (state_q == S_DONE);
  assign w_load              = (state_q == S_LOAD_W);
  assign w_row               = w_load ? row_q : '0;
  assign w_bank              = w_load ? field_q : '0;
  assign acc_clear           = (state_q == S_CLEAR);
  assign a_valid             = (state_q == S_FEED);
  assign a_idx               = a_valid ? feed_q : '0;
  assign r_shift             = (state_q == S_DRAIN);
  assign r_row               = r_shift ? row_q : '0;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst || (!busy_q && start)) begin
      perf_q <= '0;
    end else if (busy_q && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign busy_cycles = perf_q;
`else
  assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench for systolic_sequencer: per-instruction expected-output schedule model,
// per-cycle compare, directed programs with literal pins, then randomized programs with random resets.
module tb_systolic_sequencer;

  localparam int N     = 4;
  localparam int RW    = $clog2(N);
  localparam int FLUSH = 7;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          w_load;
    logic [RW-1:0] w_row;
    logic [2:0]    w_bank;
    logic          acc_clear;
    logic          a_valid;
    logic [2:0]    a_idx;
    logic          r_shift;
    logic [RW-1:0] r_row;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [4:0]    instruction = 5'd0;
  logic          systolic_array_done, busy, w_load, acc_clear, a_valid, r_shift;
  logic [RW-1:0] w_row, r_row;
  logic [2:0]    w_bank, a_idx;
  logic [15:0]   busy_cycles;

  systolic_sequencer #(.ARRAY_N(N), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst), .start(start), .instruction(instruction),
    .systolic_array_done(systolic_array_done), .busy(busy),
    .w_load(w_load), .w_row(w_row), .w_bank(w_bank), .acc_clear(acc_clear),
    .a_valid(a_valid), .a_idx(a_idx), .r_shift(r_shift), .r_row(r_row),
    .busy_cycles(busy_cycles)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Each decoded instruction appends its whole expected output trace to a queue;
  // an empty queue means the sequencer sits in an idle/decode slot.
  exp_t        sched[$];
  exp_t        cur = '0;
  bit          cur_idle = 1'b1;
  bit          m_busy = 1'b0;
  logic [15:0] m_perf = 16'd0;

  function automatic exp_t base_vec();
    exp_t e;
    e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  task automatic plan(input logic [4:0] word);
    exp_t e;
    int   f;
    f = int'(word[2:0]);
    case (word[4:3])
      2'b01: for (int i = 0; i < N; i++) begin
        e = base_vec(); e.w_load = 1'b1; e.w_row = RW'(i); e.w_bank = word[2:0];
        sched.push_back(e);
      end
      2'b10: begin
        e = base_vec(); e.acc_clear = 1'b1;
        sched.push_back(e);
        for (int i = 0; i <= f; i++) begin
          e = base_vec(); e.a_valid = 1'b1; e.a_idx = 3'(i);
          sched.push_back(e);
        end
        for (int i = 0; i < FLUSH; i++) sched.push_back(base_vec());
      end
      2'b11: for (int i = 0; i < N; i++) begin
        e = base_vec(); e.r_shift = 1'b1; e.r_row = RW'(i);
        sched.push_back(e);
      end
      default: ;
    endcase
    e = base_vec(); e.done = 1'b1;
    sched.push_back(e);
    sched.push_back(base_vec());
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      sched.delete();
      m_perf = 16'd0;
    end else begin
`ifdef SEQ_PERF_CNT_EN
      if (!cur.busy && start) m_perf = 16'd0;
      else if (cur.busy && m_perf != 16'hFFFF) m_perf = m_perf + 16'd1;
`endif
      if (cur_idle) begin
        if (!m_busy) m_busy = start;
        else if (instruction == 5'd0) m_busy = 1'b0;
        else plan(instruction);
      end
    end
    if (sched.size() > 0) begin
      cur      = sched.pop_front();
      cur_idle = 1'b0;
    end else begin
      cur      = '0;
      cur.busy = m_busy;
      cur_idle = 1'b1;
    end
  end

  // ---------------- bench state ----------------
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [4:0] prog[8];
  int         pc = 0;
  int         n_done = 0, n_wload = 0, n_avalid = 0, n_rshift = 0, n_clear = 0;
  int         rise_cyc = 0, first_done_cyc = 0;
  bit         busy_prev = 1'b0, done_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Drive inputs for the next edge, advance to the following negedge, compare and tally.
  task automatic step(input bit s, input bit r);
    exp_t got;
    start = s;
    rst   = r;
    instruction = (cur_idle && m_busy) ? prog[pc] : 5'($urandom);
    @(negedge clk);
    cyc++;
    got = '{busy, systolic_array_done, w_load, w_row, w_bank, acc_clear,
            a_valid, a_idx, r_shift, r_row};
    vectors++;
    if (got !== cur) begin
      miscompares++;
      $display("FAIL outputs @cycle %0d: got %b expected %b (busy,done,w_load,w_row,w_bank,clr,a_valid,a_idx,r_shift,r_row)",
               cyc, got, cur);
    end
    check("busy_cycles", 32'(busy_cycles), 32'(m_perf));
    if (systolic_array_done && pc < 7) pc++;
    if (busy && !busy_prev) begin
      rise_cyc  = cyc;
      done_seen = 1'b0;
    end
    if (systolic_array_done && !done_seen) begin
      first_done_cyc = cyc;
      done_seen      = 1'b1;
    end
    busy_prev = busy;
    n_done   += int'(systolic_array_done);
    n_wload  += int'(w_load);
    n_avalid += int'(a_valid);
    n_rshift += int'(r_shift);
    n_clear  += int'(acc_clear);
  endtask

  task automatic load(input logic [4:0] w0, input logic [4:0] w1,
                      input logic [4:0] w2, input logic [4:0] w3);
    for (int i = 0; i < 8; i++) prog[i] = 5'd0;
    prog[0] = w0; prog[1] = w1; prog[2] = w2; prog[3] = w3;
  endtask

  // Pulse start, then run until busy drops; abort_at >= 0 asserts rst that many cycles after the decode slot.
  task automatic run(input int gap, input int abort_at, input bit noisy_start);
    bit ended;
    pc = 0;
    ended = 1'b0;
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int k = 0; k < 400; k++) begin
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      step(noisy_start && ($urandom_range(0, 3) == 0), k == abort_at);
    end
    if (!ended) check("run_timeout", 32'(busy), 32'd0);
    step(1'b0, 1'b0);
  endtask

  int d0, w0, a0, r0, c0;

  task automatic snap();
    d0 = n_done; w0 = n_wload; a0 = n_avalid; r0 = n_rshift; c0 = n_clear;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) prog[i] = 5'd0;
    repeat (3) step(1'b0, 1'b1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(systolic_array_done), 32'd0);
    check("reset_perf", 32'(busy_cycles), 32'd0);
    repeat (2) step(1'b0, 1'b0);

    // LOAD_W bank 2 then HALT
    load(5'b01_010, 5'd0, 5'd0, 5'd0);
    snap();
    run(1, -1, 1'b0);
    check("ldw_wload_cycles", 32'(n_wload - w0), 32'd4);
    check("ldw_done_pulses", 32'(n_done - d0), 32'd1);
    check("ldw_latency", 32'(first_done_cyc - rise_cyc), 32'd5);
    check("ldw_busy_low", 32'(busy), 32'd0);
`ifdef SEQ_PERF_CNT_EN
    check("perf_ldw_halt", 32'(busy_cycles), 32'd8);
`else
    check("perf_disabled", 32'(busy_cycles), 32'd0);
`endif

    // COMPUTE field 3
    load(5'b10_011, 5'd0, 5'd0, 5'd0);
    snap();
    run(2, -1, 1'b0);
    check("cmp_clear_cycles", 32'(n_clear - c0), 32'd1);
    check("cmp_avalid_cycles", 32'(n_avalid - a0), 32'd4);
    check("cmp_latency", 32'(first_done_cyc - rise_cyc), 32'd13);

    // LOAD_W, COMPUTE, DRAIN, HALT
    load(5'b01_000, 5'b10_000, 5'b11_001, 5'd0);
    snap();
    run(0, -1, 1'b1);
    check("seq3_done_pulses", 32'(n_done - d0), 32'd3);
    check("seq3_rshift_cycles", 32'(n_rshift - r0), 32'd4);

    // NOP then LOAD_W
    load(5'b00_101, 5'b01_001, 5'd0, 5'd0);
    snap();
    run(1, -1, 1'b0);
    check("nop_latency", 32'(first_done_cyc - rise_cyc), 32'd1);
    check("nop_done_pulses", 32'(n_done - d0), 32'd2);
    check("nop_wload_cycles", 32'(n_wload - w0), 32'd4);

    // Reset during the second FEED cycle, then a clean restart
    load(5'b10_011, 5'd0, 5'd0, 5'd0);
    snap();
    run(1, 3, 1'b0);
    check("rst_no_done", 32'(n_done - d0), 32'd0);
    check("rst_avalid_cycles", 32'(n_avalid - a0), 32'd2);
    check("rst_outputs_idle", 32'({busy, a_valid, acc_clear, w_load, r_shift}), 32'd0);
    snap();
    run(0, -1, 1'b0);
    check("restart_done", 32'(n_done - d0), 32'd1);

    // Randomized programs with noisy start, junk on instruction mid-run and occasional reset
    for (int t = 0; t < 40; t++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int i = 0; i < 8; i++) prog[i] = 5'd0;
      for (int i = 0; i < len; i++) prog[i] = 5'($urandom_range(1, 31));
      run($urandom_range(0, 3),
          ($urandom_range(0, 5) == 0) ? $urandom_range(0, 40) : -1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
